// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the CPU memory responder: FSM encoding, default
// backing-memory word-address width and the empty byte-mask constant.
package riscv_mem_pkg;

  localparam int MEM_ADDR_W_DEF = 30;
  localparam int DATA_W_DEF     = 32;

  localparam logic [3:0] MASK_NONE = 4'b0000;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_D_REQ  = 3'd1;
  localparam logic [2:0] ENC_D_WAIT = 3'd2;
  localparam logic [2:0] ENC_I_REQ  = 3'd3;
  localparam logic [2:0] ENC_I_WAIT = 3'd4;
  localparam logic [2:0] ENC_DONE   = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE   = ENC_IDLE,
    ST_D_REQ  = ENC_D_REQ,
    ST_D_WAIT = ENC_D_WAIT,
    ST_I_REQ  = ENC_I_REQ,
    ST_I_WAIT = ENC_I_WAIT,
    ST_DONE   = ENC_DONE
  } state_t;

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Bundle of CPU cache-port and backing-memory signals around the responder.
// master = the responder itself, slave = the CPU/memory environment.
interface riscv_mem_responder_if
  import riscv_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF
) ();

  logic [31:0]           icache_addr;
  logic                  icache_re;
  logic [31:0]           dcache_addr;
  logic                  dcache_re;
  logic [3:0]            dcache_we;
  logic [31:0]           dcache_din;
  logic [31:0]           icache_dout;
  logic [31:0]           dcache_dout;
  logic                  stall;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic                  mem_req_rw;
  logic [MEM_ADDR_W-1:0] mem_req_addr;
  logic [31:0]           mem_req_data;
  logic [3:0]            mem_req_mask;
  logic                  mem_resp_valid;
  logic [31:0]           mem_resp_data;

  modport master (
    input  icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output icache_dout, dcache_dout, stall,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

  modport slave (
    output icache_addr, icache_re, dcache_addr, dcache_re, dcache_we, dcache_din,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  icache_dout, dcache_dout, stall,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
  );

endinterface

// File: rtl/riscv_mem_responder_ibuf.sv
// One-entry instruction buffer used by riscv_mem_responder when
// RISCV_MEM_IBUF_EN is defined; the module does not exist otherwise.
`ifdef RISCV_MEM_IBUF_EN
module riscv_mem_ibuf
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data,
  input  logic              i_fill,
  input  logic [ADDR_W-1:0] i_fill_addr,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_inv,
  input  logic [ADDR_W-1:0] i_inv_addr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_inv_match;

  // A store retiring this cycle to the buffered word already counts as a miss.
  assign w_inv_match = i_inv && (i_inv_addr == r_addr);
  assign o_hit       = r_valid && (i_lookup_addr == r_addr) && !w_inv_match;
  assign o_hit_data  = r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_addr  <= i_fill_addr;
      r_data  <= i_fill_data;
    end else if (w_inv_match) begin
      r_valid <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/riscv_mem_responder.sv
// Serialises the core's icache/dcache ports onto one backing-memory port and
// owns stall. Optional one-entry fetch buffer under RISCV_MEM_IBUF_EN.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_mem_responder_if.master bus
);

  typedef logic [MEM_ADDR_W-1:0] waddr_t;

  state_t            r_state, w_next;
  logic              r_stall;
  logic              r_i_re;
  waddr_t            r_i_waddr;
  logic [3:0]        r_d_we;
  waddr_t            r_d_waddr;
  logic [DATA_W-1:0] r_d_din;
  logic [DATA_W-1:0] r_i_dout, r_d_dout;

  waddr_t            w_i_waddr_in, w_d_waddr_in, w_lookup_waddr;
  logic              w_d_pend_in, w_i_hit, w_fill, w_inv;
  logic              w_ld_d, w_ld_i, w_ld_ibuf;
  logic [DATA_W-1:0] w_ibuf_data;
  logic              w_after_d_ldbuf;
  state_t            w_after_d;
  logic              w_req_valid, w_req_rw;
  waddr_t            w_req_addr;
  logic [DATA_W-1:0] w_req_data;
  logic [3:0]        w_req_mask;
  logic              w_unused_addr;

  assign w_i_waddr_in  = bus.icache_addr[MEM_ADDR_W+1:2];
  assign w_d_waddr_in  = bus.dcache_addr[MEM_ADDR_W+1:2];
  assign w_unused_addr = ^{bus.icache_addr[1:0], bus.dcache_addr[1:0]};
  assign w_d_pend_in   = bus.dcache_re || (bus.dcache_we != MASK_NONE);

  // Lookup uses the live fetch address at capture, the latched one afterwards.
  assign w_lookup_waddr = r_stall ? r_i_waddr : w_i_waddr_in;
  assign w_fill = (r_state == ST_I_WAIT) && bus.mem_resp_valid;
  assign w_inv  = (r_state == ST_D_REQ) && bus.mem_req_ready && (r_d_we != MASK_NONE);

`ifdef RISCV_MEM_IBUF_EN
  riscv_mem_ibuf #(
    .ADDR_W (MEM_ADDR_W),
    .DATA_W (DATA_W)
  ) u_ibuf (
    .clk           (clk),
    .reset         (reset),
    .i_lookup_addr (w_lookup_waddr),
    .o_hit         (w_i_hit),
    .o_hit_data    (w_ibuf_data),
    .i_fill        (w_fill),
    .i_fill_addr   (r_i_waddr),
    .i_fill_data   (bus.mem_resp_data),
    .i_inv         (w_inv),
    .i_inv_addr    (r_d_waddr)
  );
`else
  logic w_unused_ibuf;
  assign w_i_hit       = 1'b0;
  assign w_ibuf_data   = '0;
  assign w_unused_ibuf = ^{w_fill, w_inv, w_lookup_waddr};
`endif

  // Where to go once the data access has finished.
  always_comb begin
    w_after_d       = ST_DONE;
    w_after_d_ldbuf = 1'b0;
    if (r_i_re && w_i_hit) begin
      w_after_d_ldbuf = 1'b1;
    end else if (r_i_re) begin
      w_after_d = ST_I_REQ;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_req_valid = 1'b0;
    w_req_rw    = 1'b0;
    w_req_addr  = '0;
    w_req_data  = '0;
    w_req_mask  = MASK_NONE;
    w_ld_d      = 1'b0;
    w_ld_i      = 1'b0;
    w_ld_ibuf   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_d_pend_in) begin
          w_next = ST_D_REQ;
        end else if (bus.icache_re && w_i_hit) begin
          w_next    = ST_DONE;
          w_ld_ibuf = 1'b1;
        end else if (bus.icache_re) begin
          w_next = ST_I_REQ;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_D_REQ: begin
        w_req_valid = 1'b1;
        w_req_rw    = (r_d_we != MASK_NONE);
        w_req_addr  = r_d_waddr;
        w_req_data  = r_d_din;
        w_req_mask  = r_d_we;
        if (bus.mem_req_ready) begin
          if (w_req_rw) begin
            w_next    = w_after_d;
            w_ld_ibuf = w_after_d_ldbuf;
          end else begin
            w_next = ST_D_WAIT;
          end
        end
      end
      ST_D_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_ld_d    = 1'b1;
          w_next    = w_after_d;
          w_ld_ibuf = w_after_d_ldbuf;
        end
      end
      ST_I_REQ: begin
        w_req_valid = 1'b1;
        w_req_addr  = r_i_waddr;
        if (bus.mem_req_ready) w_next = ST_I_WAIT;
      end
      ST_I_WAIT: begin
        if (bus.mem_resp_valid) begin
          w_ld_i = 1'b1;
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_stall <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stall <= !((w_next == ST_IDLE) || (w_next == ST_DONE));
    end
  end

  // Request capture happens on every edge the core is not frozen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_re    <= 1'b0;
      r_i_waddr <= '0;
      r_d_we    <= MASK_NONE;
      r_d_waddr <= '0;
      r_d_din   <= '0;
      r_i_dout  <= '0;
      r_d_dout  <= '0;
    end else begin
      if (!r_stall) begin
        r_i_re    <= bus.icache_re;
        r_i_waddr <= w_i_waddr_in;
        r_d_we    <= bus.dcache_we;
        r_d_waddr <= w_d_waddr_in;
        r_d_din   <= bus.dcache_din;
      end
      if (w_ld_d) r_d_dout <= bus.mem_resp_data;
      if (w_ld_i) begin
        r_i_dout <= bus.mem_resp_data;
      end else if (w_ld_ibuf) begin
        r_i_dout <= w_ibuf_data;
      end
    end
  end

  assign bus.icache_dout   = r_i_dout;
  assign bus.dcache_dout   = r_d_dout;
  assign bus.stall         = r_stall;
  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_rw    = w_req_rw;
  assign bus.mem_req_addr  = w_req_addr;
  assign bus.mem_req_data  = w_req_data;
  assign bus.mem_req_mask  = w_req_mask;

endmodule
